// File: rtl/ad9361_rx_deframer.sv
// AD9361 RX deframer: aligns to RX_FRAME from the IDDR outputs and emits registered I/Q sample sets.
// Optional macro AD9361_RX_SIGN_EXT_EN: sign-extend samples to OUT_W (zero-extend when undefined).
module ad9361_rx_deframer #(
  parameter int DATA_W   = 12,
  parameter int OUT_W    = 16,
  parameter int NUM_CH   = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] bus_he,
  input  logic [DATA_W-1:0] bus_le,
  input  logic              frm_he,
  input  logic              frm_le,
  input  logic              err_clr,
  output logic              rx_valid,
  output logic [OUT_W-1:0]  rx_i0,
  output logic [OUT_W-1:0]  rx_q0,
  output logic [OUT_W-1:0]  rx_i1,
  output logic [OUT_W-1:0]  rx_q1,
  output logic              locked,
  output logic [15:0]       frm_err_cnt
);

  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_t;

  state_t            state_r;
  logic [7:0]        good_cnt_r;
  logic              phase_r;
  logic [DATA_W-1:0] hold_i_r;
  logic [DATA_W-1:0] hold_q_r;

  logic slot0_s;
  logic slot1_s;
  logic one_s;
  logic pat_ok_s;
  logic first_slot_s;
  logic err_evt_s;

  function automatic logic [OUT_W-1:0] extend(input logic [DATA_W-1:0] v);
`ifdef AD9361_RX_SIGN_EXT_EN
    extend = OUT_W'($signed(v));
`else
    extend = OUT_W'(v);
`endif
  endfunction

  assign slot0_s      = frm_he & frm_le;
  assign slot1_s      = ~frm_he & ~frm_le;
  assign one_s        = frm_he & ~frm_le;
  assign first_slot_s = (NUM_CH == 2) && !phase_r;
  assign err_evt_s    = (state_r == LOCK) && !pat_ok_s;

  // Expected RX_FRAME pattern for the current slot position.
  always_comb begin
    pat_ok_s = 1'b0;
    if (NUM_CH == 2) begin
      if (phase_r) begin
        pat_ok_s = slot1_s;
      end else begin
        pat_ok_s = slot0_s;
      end
    end else begin
      pat_ok_s = one_s;
    end
  end

  // Saturating frame error counter; a coincident error wins over the clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frm_err_cnt <= 16'h0000;
    end else if (err_clr) begin
      frm_err_cnt <= err_evt_s ? 16'h0001 : 16'h0000;
    end else if (err_evt_s && (frm_err_cnt != 16'hFFFF)) begin
      frm_err_cnt <= frm_err_cnt + 16'h0001;
    end
  end

  // Alignment FSM with registered sample outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= SEARCH;
      good_cnt_r <= 8'd0;
      phase_r    <= 1'b0;
      hold_i_r   <= '0;
      hold_q_r   <= '0;
      rx_valid   <= 1'b0;
      locked     <= 1'b0;
      rx_i0      <= '0;
      rx_q0      <= '0;
      rx_i1      <= '0;
      rx_q1      <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state_r)
        SEARCH: begin
          if (pat_ok_s && first_slot_s) begin
            hold_i_r <= bus_he;
            hold_q_r <= bus_le;
            phase_r  <= 1'b1;
          end else if (pat_ok_s) begin
            phase_r <= 1'b0;
            if (good_cnt_r == 8'(LOCK_CNT - 1)) begin
              state_r    <= LOCK;
              locked     <= 1'b1;
              good_cnt_r <= 8'd0;
            end else begin
              good_cnt_r <= good_cnt_r + 8'd1;
            end
          end else begin
            // A stray slot0 in slot1 position still opens a fresh frame.
            good_cnt_r <= 8'd0;
            if ((NUM_CH == 2) && slot0_s) begin
              hold_i_r <= bus_he;
              hold_q_r <= bus_le;
              phase_r  <= 1'b1;
            end else begin
              phase_r <= 1'b0;
            end
          end
        end
        LOCK: begin
          if (pat_ok_s && first_slot_s) begin
            hold_i_r <= bus_he;
            hold_q_r <= bus_le;
            phase_r  <= 1'b1;
          end else if (pat_ok_s) begin
            phase_r  <= 1'b0;
            rx_valid <= 1'b1;
            if (NUM_CH == 2) begin
              rx_i0 <= extend(hold_i_r);
              rx_q0 <= extend(hold_q_r);
              rx_i1 <= extend(bus_he);
              rx_q1 <= extend(bus_le);
            end else begin
              rx_i0 <= extend(bus_he);
              rx_q0 <= extend(bus_le);
            end
          end else begin
            state_r    <= SEARCH;
            locked     <= 1'b0;
            good_cnt_r <= 8'd0;
            phase_r    <= 1'b0;
          end
        end
        default: begin
          state_r    <= SEARCH;
          locked     <= 1'b0;
          good_cnt_r <= 8'd0;
          phase_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9361_rx_deframer.sv
// Scoreboard bench for ad9361_rx_deframer: 1R lock-4, 2R lock-4 and 1R lock-1 (error counter) instances.
`timescale 1ns/1ps
module tb_ad9361_rx_deframer;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [63:0] last_a;
  logic [63:0] last_b;

  logic        a_rst, a_fh, a_fl, a_clr, a_valid, a_locked;
  logic [11:0] a_he, a_le;
  logic [15:0] a_i0, a_q0, a_i1, a_q1, a_err;
  logic        b_rst, b_fh, b_fl, b_clr, b_valid, b_locked;
  logic [11:0] b_he, b_le;
  logic [15:0] b_i0, b_q0, b_i1, b_q1, b_err;
  logic        c_rst, c_fh, c_fl, c_clr, c_valid, c_locked;
  logic [11:0] c_he, c_le;
  logic [15:0] c_i0, c_q0, c_i1, c_q1, c_err;

  ad9361_rx_deframer #(.DATA_W(12), .OUT_W(16), .NUM_CH(1), .LOCK_CNT(4)) dut_a (
    .sys_clk(clk), .sys_rst(a_rst), .bus_he(a_he), .bus_le(a_le), .frm_he(a_fh), .frm_le(a_fl),
    .err_clr(a_clr), .rx_valid(a_valid), .rx_i0(a_i0), .rx_q0(a_q0), .rx_i1(a_i1), .rx_q1(a_q1),
    .locked(a_locked), .frm_err_cnt(a_err));

  ad9361_rx_deframer #(.DATA_W(12), .OUT_W(16), .NUM_CH(2), .LOCK_CNT(4)) dut_b (
    .sys_clk(clk), .sys_rst(b_rst), .bus_he(b_he), .bus_le(b_le), .frm_he(b_fh), .frm_le(b_fl),
    .err_clr(b_clr), .rx_valid(b_valid), .rx_i0(b_i0), .rx_q0(b_q0), .rx_i1(b_i1), .rx_q1(b_q1),
    .locked(b_locked), .frm_err_cnt(b_err));

  ad9361_rx_deframer #(.DATA_W(12), .OUT_W(16), .NUM_CH(1), .LOCK_CNT(1)) dut_c (
    .sys_clk(clk), .sys_rst(c_rst), .bus_he(c_he), .bus_le(c_le), .frm_he(c_fh), .frm_le(c_fl),
    .err_clr(c_clr), .rx_valid(c_valid), .rx_i0(c_i0), .rx_q0(c_q0), .rx_i1(c_i1), .rx_q1(c_q1),
    .locked(c_locked), .frm_err_cnt(c_err));

  function automatic logic [15:0] ext(input logic [11:0] v);
`ifdef AD9361_RX_SIGN_EXT_EN
    return {{4{v[11]}}, v};
`else
    return {4'h0, v};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobes from the 1R instance are matched against the queue in order and by cycle.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_valid === 1'b1) begin
      check("a_strobe_expected", 64'(qa.size() > 0), 64'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_data", {a_i0, a_q0, a_i1, a_q1}, e.data);
        check("a_strobe_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_valid === 1'b1) begin
      check("b_strobe_expected", 64'(qb.size() > 0), 64'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_data", {b_i0, b_q0, b_i1, b_q1}, e.data);
        check("b_strobe_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step_a(input logic fh, input logic fl, input logic [11:0] he, input logic [11:0] le,
                        input logic push);
    exp_t e;
    a_fh = fh; a_fl = fl; a_he = he; a_le = le;
    if (push) begin
      e.data = {ext(he), ext(le), 32'h0};
      e.cyc  = cyc + 1;
      qa.push_back(e);
      last_a = e.data;
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic fh, input logic fl, input logic [11:0] he, input logic [11:0] le);
    b_fh = fh; b_fl = fl; b_he = he; b_le = le;
    @(posedge clk); #1;
  endtask

  task automatic frame_b(input logic [11:0] i0, input logic [11:0] q0, input logic [11:0] i1,
                         input logic [11:0] q1, input logic push);
    exp_t e;
    step_b(1'b1, 1'b1, i0, q0);
    b_fh = 1'b0; b_fl = 1'b0; b_he = i1; b_le = q1;
    if (push) begin
      e.data = {ext(i0), ext(q0), ext(i1), ext(q1)};
      e.cyc  = cyc + 1;
      qb.push_back(e);
      last_b = e.data;
    end
    @(posedge clk); #1;
  endtask

  task automatic step_c(input logic fh, input logic fl, input logic clr);
    c_fh = fh; c_fl = fl; c_clr = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [11:0] r0, r1, r2, r3;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_fh = 1'b0; a_fl = 1'b0; a_he = 12'h0; a_le = 12'h0; a_clr = 1'b0;
    b_fh = 1'b0; b_fl = 1'b0; b_he = 12'h0; b_le = 12'h0; b_clr = 1'b0;
    c_fh = 1'b0; c_fl = 1'b0; c_he = 12'h0; c_le = 12'h0; c_clr = 1'b0;
    last_a = 64'h0; last_b = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_outputs", {a_i0, a_q0, a_i1, a_q1}, 64'h0);
    check("a_rst_flags", {46'h0, a_valid, a_locked, a_err}, 64'h0);
    check("b_rst_outputs", {b_i0, b_q0, b_i1, b_q1}, 64'h0);
    check("c_rst_err", 64'(c_err), 64'h0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // 1R lock and streaming
    for (int k = 0; k < 3; k++) begin
      step_a(1'b1, 1'b0, 12'h801, 12'h7FF, 1'b0);
      check("a_locked_before_cnt", 64'(a_locked), 64'd0);
    end
    step_a(1'b1, 1'b0, 12'h801, 12'h7FF, 1'b0);
    check("a_locked_at_cnt", 64'(a_locked), 64'd1);
    step_a(1'b1, 1'b0, 12'h801, 12'h7FF, 1'b1);
    check("a_spec_i0", 64'(a_i0), 64'(ext(12'h801)));
    check("a_spec_q0", 64'(a_q0), 64'(ext(12'h7FF)));
    step_a(1'b1, 1'b0, 12'h801, 12'h7FF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      r0 = 12'($urandom_range(0, 4095));
      r1 = 12'($urandom_range(0, 4095));
      step_a(1'b1, 1'b0, r0, r1, 1'b1);
    end

    // 1R error in lock, then a broken search run
    step_a(1'b0, 1'b0, 12'h123, 12'h456, 1'b0);
    check("a_locked_after_err", 64'(a_locked), 64'd0);
    check("a_err_cnt", 64'(a_err), 64'd1);
    check("a_hold", {a_i0, a_q0, a_i1, a_q1}, last_a);
    for (int k = 0; k < 3; k++) step_a(1'b1, 1'b0, 12'h0AA, 12'h055, 1'b0);
    step_a(1'b1, 1'b1, 12'h0AA, 12'h055, 1'b0);
    for (int k = 0; k < 3; k++) step_a(1'b1, 1'b0, 12'h0AA, 12'h055, 1'b0);
    check("a_search_restart", 64'(a_locked), 64'd0);
    step_a(1'b1, 1'b0, 12'h0AA, 12'h055, 1'b0);
    check("a_relock", 64'(a_locked), 64'd1);
    check("a_err_search_uncounted", 64'(a_err), 64'd1);
    step_a(1'b1, 1'b0, 12'hFFF, 12'h000, 1'b1);
    step_a(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    step_a(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);

    // 2R lock and streaming
    for (int k = 0; k < 3; k++) frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_locked_before_cnt", 64'(b_locked), 64'd0);
    frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_locked_at_cnt", 64'(b_locked), 64'd1);
    for (int k = 0; k < 3; k++) frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b1);
    check("b_spec_set", {b_i0, b_q0, b_i1, b_q1}, 64'h0100_0200_0300_0400);
    for (int k = 0; k < 2; k++) begin
      r0 = 12'($urandom_range(0, 4095)); r1 = 12'($urandom_range(0, 4095));
      r2 = 12'($urandom_range(0, 4095)); r3 = 12'($urandom_range(0, 4095));
      frame_b(r0, r1, r2, r3, 1'b1);
    end

    // 2R bad slot1 while locked
    step_b(1'b1, 1'b1, 12'h111, 12'h222);
    step_b(1'b1, 1'b0, 12'h333, 12'h444);
    check("b_locked_after_err", 64'(b_locked), 64'd0);
    check("b_err_cnt", 64'(b_err), 64'd1);
    check("b_hold", {b_i0, b_q0, b_i1, b_q1}, last_b);
    for (int k = 0; k < 3; k++) frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_relock_early", 64'(b_locked), 64'd0);
    frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_relock", 64'(b_locked), 64'd1);
    frame_b(12'hABC, 12'h0DE, 12'h801, 12'h7F0, 1'b1);

    // 2R reset mid-frame while locked
    step_b(1'b1, 1'b1, 12'h555, 12'h666);
    b_rst = 1'b1;
    step_b(1'b0, 1'b0, 12'h777, 12'h888);
    b_rst = 1'b0;
    check("b_rst_outputs", {b_i0, b_q0, b_i1, b_q1}, 64'h0);
    check("b_rst_flags", {46'h0, b_valid, b_locked, b_err}, 64'h0);
    for (int k = 0; k < 3; k++) frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_rst_relock_early", 64'(b_locked), 64'd0);
    frame_b(12'h100, 12'h200, 12'h300, 12'h400, 1'b0);
    check("b_rst_relock", 64'(b_locked), 64'd1);
    frame_b(12'h012, 12'h345, 12'h678, 12'h9AB, 1'b1);
    repeat (2) step_b(1'b1, 1'b1, 12'h0, 12'h0);

    // error counter saturation on the lock-1 instance
    for (int k = 0; k < 65540; k++) begin
      step_c(1'b1, 1'b0, 1'b0);
      step_c(1'b0, 1'b0, 1'b0);
      if (k == 65534) check("c_err_at_max", 64'(c_err), 64'hFFFF);
    end
    check("c_err_saturated", 64'(c_err), 64'hFFFF);
    step_c(1'b1, 1'b0, 1'b0);
    check("c_locked", 64'(c_locked), 64'd1);
    step_c(1'b0, 1'b0, 1'b1);
    check("c_clr_with_err", 64'(c_err), 64'd1);
    step_c(1'b0, 1'b0, 1'b1);
    check("c_clr_alone", 64'(c_err), 64'd0);

    check("a_pending", 64'(qa.size()), 64'd0);
    check("b_pending", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
